// File: rtl/leb128_pkg.sv
// Shared types and helpers for the LEB128 stream decoder.
package leb128_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // Bytes needed to carry w payload bits at 7 bits per byte.
  function automatic int maxb(input int w);
    return (w + 6) / 7;
  endfunction

endpackage

// File: rtl/leb128_acc.sv
// LEB128 accumulator: payload placement, byte count, last-byte range check and
// optional SLEB128 sign handling (LEB128_SIGNED_EN).
module leb128_acc
  import leb128_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef LEB128_SIGNED_EN
  input  logic         sgn_i,
`endif
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [6:0]   payload_i,
  output logic [W-1:0] acc_o,
  output logic [3:0]   cnt_o,
  output logic         hi_bad_o
);

  localparam int MAXB = maxb(W);
  // Lowest payload bit of the final byte that falls at or above bit W.
  localparam int HB   = W - 7 * (MAXB - 1);

  logic [W-1:0] acc_q, acc_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [6:0]   shamt;

  assign shamt = 7'(cnt_q) * 7'd7;

  always_comb begin
    // NOTE: defaults first so every path assigns the next state and no latch is inferred.
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (load_i) begin
      acc_d = acc_q | (W'(payload_i) << shamt);
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking for all state so each register samples pre-edge values.
    if (!rst_n) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

`ifdef LEB128_SIGNED_EN
  logic         sgn_q, sgn_d;
  logic         sign_bit;
  logic [W-1:0] ext_mask;

  always_comb begin
    sgn_d = sgn_q;
    if (clr_i)                        sgn_d = 1'b0;
    else if (load_i && cnt_q == 4'd0) sgn_d = sgn_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sgn_q <= 1'b0;
    else        sgn_q <= sgn_d;
  end

  // Both shifts yield zero once 7*len reaches W, which disables extension.
  assign sign_bit = |(acc_q & (W'(1) << (shamt - 7'd1)));
  assign ext_mask = {W{1'b1}} << shamt;
  assign acc_o    = (sgn_q && cnt_q != 4'd0 && sign_bit) ? (acc_q | ext_mask) : acc_q;

  // Signed: dropped bits must replicate the value's top bit (all 0 or all 1).
  assign hi_bad_o = sgn_q ? !((&payload_i[6:HB-1]) || !(|payload_i[6:HB-1]))
                          : |payload_i[6:HB];
`else
  assign acc_o    = acc_q;
  assign hi_bad_o = |payload_i[6:HB];
`endif

endmodule

// File: rtl/leb128_stream_dec.sv
// LEB128 byte-stream decoder top: FSM and input/output handshakes.
// Define LEB128_SIGNED_EN to add the sgn port and SLEB128 decoding.
module leb128_stream_dec
  import leb128_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
`ifdef LEB128_SIGNED_EN
  input  logic         sgn,
`endif
  input  logic [7:0]   i_data,
  input  logic         i_valid,
  output logic         i_ready,
  output logic [W-1:0] o_data,
  output logic [3:0]   o_len,
  output logic         o_err,
  output logic         o_valid,
  input  logic         o_ready
);

  localparam int MAXB = maxb(W);

  state_e state_q, state_d;
  logic   err_q, err_d;
  logic   ovl_q, ovl_d;
  logic   accept, last, hi_bad, load, clr;
  logic [3:0] cnt;

  leb128_acc #(.W(W)) u_acc (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef LEB128_SIGNED_EN
    .sgn_i     (sgn),
`endif
    .clr_i     (clr),
    .load_i    (load),
    .payload_i (i_data[6:0]),
    .acc_o     (o_data),
    .cnt_o     (cnt),
    .hi_bad_o  (hi_bad)
  );

  // i_ready depends on state only, never on o_ready.
  assign i_ready = (state_q != OUT);
  assign o_valid = (state_q == OUT);
  assign o_len   = cnt;
  assign o_err   = err_q;
  assign accept  = i_valid && i_ready;
  assign last    = (cnt == 4'(MAXB - 1));

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    ovl_d   = ovl_q;
    load    = 1'b0;
    clr     = 1'b0;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          load = 1'b1;
          if (!i_data[7]) begin
            state_d = OUT;
            err_d   = last && hi_bad;
            ovl_d   = 1'b0;
          end else if (last) begin
            state_d = OUT;
            err_d   = 1'b1;
            ovl_d   = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      OUT: begin
        if (o_ready) begin
          clr     = 1'b1;
          err_d   = 1'b0;
          ovl_d   = 1'b0;
          state_d = ovl_q ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (accept && !i_data[7]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      ovl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      ovl_q   <= ovl_d;
    end
  end

endmodule

// File: tb/tb_leb128_stream_dec.sv
// Self-checking bench for leb128_stream_dec: directed table, corner sequences
// and a random byte stream scored against a wide-arithmetic decode model.
module tb_leb128_stream_dec;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [7:0]   i_data = 8'h00;
  logic         i_valid = 1'b0;
  logic         o_ready = 1'b1;
  logic         i_ready;
  logic [W-1:0] o_data;
  logic [3:0]   o_len;
  logic         o_err;
  logic         o_valid;
`ifdef LEB128_SIGNED_EN
  logic         sgn = 1'b0;
`endif

  leb128_stream_dec #(.W(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
`ifdef LEB128_SIGNED_EN
    .sgn     (sgn),
`endif
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_ready (i_ready),
    .o_data  (o_data),
    .o_len   (o_len),
    .o_err   (o_err),
    .o_valid (o_valid),
    .o_ready (o_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    int          len;
    bit          err;
  } res_t;

  typedef struct {
    int             n;
    logic [0:12][7:0] b;
    res_t           e0;
    bit             has_e1;
    res_t           e1;
  } vec_t;

  res_t       exp_q[$];
  logic [7:0] stream_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         done;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Scoreboard: every output handshake is matched against the expected queue.
  res_t mon_e;
  always @(negedge clk) begin
    if (rst_n && o_valid && o_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_output: got data 0x%0h len %0d err %0d, expected none",
                 o_data, o_len, o_err);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_data", o_data, mon_e.data);
        check("out_len", 64'(o_len), 64'(mon_e.len));
        check("out_err", 64'(o_err), 64'(mon_e.err));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    i_data  = b;
    i_valid = 1'b1;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = i_ready;
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: byte 0x%0h got no i_ready, required within 200 cycles", b);
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int k = 0; k < 500 && !ok; k++) begin
      @(negedge clk);
      ok = (exp_q.size() == 0);
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d outputs still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Reference decode: sum payloads with wide arithmetic, then apply the
  // 10-byte limit, overflow-above-bit-63 and drain rules to the byte stream.
  task automatic model_stream();
    int          i = 0;
    logic [139:0] v;
    int          n;
    bit          cont;
    bit          c2;
    res_t        r;
    while (i < stream_q.size()) begin
      v    = '0;
      n    = 0;
      cont = 1'b1;
      while (cont && n < 10 && i < stream_q.size()) begin
        v    = v | (140'(stream_q[i][6:0]) << (7 * n));
        cont = stream_q[i][7];
        n++;
        i++;
      end
      r.data = v[63:0];
      r.len  = n;
      if (cont) begin
        r.err = 1'b1;
        while (i < stream_q.size()) begin
          c2 = stream_q[i][7];
          i++;
          if (!c2) break;
        end
      end else begin
        r.err = ((v >> 64) != 0);
      end
      exp_q.push_back(r);
    end
  endtask

  vec_t tbl[8];

  initial begin
    tbl[0] = '{n: 3,  b: {8'hE5, 8'h8E, 8'h26, 80'h0},
               e0: '{64'd624485, 3, 1'b0}, has_e1: 1'b0, e1: '{64'd0, 0, 1'b0}};
    tbl[1] = '{n: 10, b: {{9{8'hFF}}, 8'h01, 24'h0},
               e0: '{64'hFFFF_FFFF_FFFF_FFFF, 10, 1'b0}, has_e1: 1'b0, e1: '{64'd0, 0, 1'b0}};
    tbl[2] = '{n: 10, b: {{9{8'hFF}}, 8'h03, 24'h0},
               e0: '{64'hFFFF_FFFF_FFFF_FFFF, 10, 1'b1}, has_e1: 1'b0, e1: '{64'd0, 0, 1'b0}};
    tbl[3] = '{n: 13, b: {{11{8'h80}}, 8'h00, 8'h05},
               e0: '{64'd0, 10, 1'b1}, has_e1: 1'b1, e1: '{64'd5, 1, 1'b0}};
    tbl[4] = '{n: 10, b: {{9{8'hFF}}, 8'h00, 24'h0},
               e0: '{64'h7FFF_FFFF_FFFF_FFFF, 10, 1'b0}, has_e1: 1'b0, e1: '{64'd0, 0, 1'b0}};
    tbl[5] = '{n: 2,  b: {8'h80, 8'h01, 88'h0},
               e0: '{64'd128, 2, 1'b0}, has_e1: 1'b0, e1: '{64'd0, 0, 1'b0}};
    tbl[6] = '{n: 1,  b: {8'h7F, 96'h0},
               e0: '{64'd127, 1, 1'b0}, has_e1: 1'b0, e1: '{64'd0, 0, 1'b0}};
    tbl[7] = '{n: 11, b: {{9{8'h80}}, 8'h7E, 8'h03, 16'h0},
               e0: '{64'd0, 10, 1'b1}, has_e1: 1'b1, e1: '{64'd3, 1, 1'b0}};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_i_ready", 64'(i_ready), 64'd1);
    check("rst_o_valid", 64'(o_valid), 64'd0);
    check("rst_o_data", o_data, 64'd0);
    check("rst_o_len", 64'(o_len), 64'd0);
    check("rst_o_err", 64'(o_err), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single zero byte: o_valid exactly one cycle after acceptance.
    exp_q.push_back('{64'd0, 1, 1'b0});
    i_data  = 8'h00;
    i_valid = 1'b1;
    @(negedge clk);
    check("lat_o_valid_before", 64'(o_valid), 64'd0);
    check("lat_i_ready", 64'(i_ready), 64'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(negedge clk);
    check("lat_o_valid_after", 64'(o_valid), 64'd1);
    wait_drain();

    // Directed table.
    for (int t = 0; t < 8; t++) begin
      exp_q.push_back(tbl[t].e0);
      if (tbl[t].has_e1) exp_q.push_back(tbl[t].e1);
      for (int j = 0; j < tbl[t].n; j++) send_byte(tbl[t].b[j]);
      wait_drain();
    end

    // Output stall: values hold, i_ready low, the waiting byte is not lost.
    o_ready = 1'b0;
    exp_q.push_back('{64'd300, 2, 1'b0});
    exp_q.push_back('{64'd5, 1, 1'b0});
    send_byte(8'hAC);
    send_byte(8'h02);
    i_data  = 8'h05;
    i_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("stall_o_valid", 64'(o_valid), 64'd1);
      check("stall_o_data", o_data, 64'd300);
      check("stall_o_len", 64'(o_len), 64'd2);
      check("stall_i_ready", 64'(i_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    o_ready = 1'b1;
    begin
      bit ok = 1'b0;
      for (int k = 0; k < 50 && !ok; k++) begin
        @(negedge clk);
        ok = i_ready;
      end
      if (!ok) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stall_release: i_ready got 0, required 1 after handshake");
      end
    end
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    wait_drain();

    // Reset in the middle of a value discards held bytes.
    send_byte(8'h81);
    send_byte(8'h82);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_len", 64'(o_len), 64'd0);
    check("rst_mid_data", o_data, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.push_back('{64'd1, 1, 1'b0});
    send_byte(8'h01);
    wait_drain();

`ifdef LEB128_SIGNED_EN
    sgn = 1'b1;
    exp_q.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 1, 1'b0});
    send_byte(8'h7F);
    wait_drain();
    exp_q.push_back('{-64'sd123456, 3, 1'b0});
    send_byte(8'hC0);
    send_byte(8'hBB);
    send_byte(8'h78);
    wait_drain();
    sgn = 1'b0;
`endif

    // Random stream with random output back-pressure.
    stream_q.delete();
    for (int v = 0; v < 60; v++) begin
      int len = $urandom_range(1, 12);
      for (int j = 0; j < len; j++) begin
        logic [7:0] b = 8'($urandom_range(0, 127));
        if (j < len - 1) b[7] = 1'b1;
        else if (len == 10 && $urandom_range(0, 1) == 1) b = 8'($urandom_range(0, 1));
        stream_q.push_back(b);
      end
    end
    model_stream();
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < stream_q.size(); k++) send_byte(stream_q[k]);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          o_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    o_ready = 1'b1;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
